// File: rtl/pwr_seq.sv
// rtl/pwr_seq.sv - power-up and lock-recovery sequencer for the OCXO/PLL timing chain
// Optional feature: define PWR_SEQ_LOCK_TIMEOUT_EN for the PLL lock timeout with retry/fault.
module pwr_seq #(
  parameter logic [23:0] WARM_CYC = 24'd5_000_000,
  parameter logic [15:0] RST_CYC  = 16'd100,
  parameter logic [15:0] STEP_CYC = 16'd5000,
  parameter logic [23:0] LOCK_CYC = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       locked,
  output logic       ocxo_ena,
  output logic       pll_rst_n,
  output logic       dac_ena,
  output logic       gps_ena,
  output logic       disp_ena,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_WARM  = 3'd1,
    S_PRST  = 3'd2,
    S_PWAIT = 3'd3,
    S_DAC   = 3'd4,
    S_GPS   = 3'd5,
    S_RUN   = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  state_t      cur_st;
  logic [23:0] ctr;
  logic [1:0]  lock_sync;
  logic        lock_s;
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
  logic [1:0]  retry;
`endif

  assign lock_s = lock_sync[1];
  assign state  = cur_st;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync <= 2'b00;
    else        lock_sync <= {lock_sync[0], locked};
  end

  // Sequencer: state, shared down-counter and registered enables move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st    <= S_OFF;
      ctr       <= 24'd0;
      ocxo_ena  <= 1'b0;
      pll_rst_n <= 1'b0;
      dac_ena   <= 1'b0;
      gps_ena   <= 1'b0;
      disp_ena  <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
      retry     <= 2'd0;
`endif
    end else if (!en) begin
      // Disable wins over everything, including mid-count and lock changes
      cur_st    <= S_OFF;
      ctr       <= 24'd0;
      ocxo_ena  <= 1'b0;
      pll_rst_n <= 1'b0;
      dac_ena   <= 1'b0;
      gps_ena   <= 1'b0;
      disp_ena  <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
      retry     <= 2'd0;
`endif
    end else begin
      case (cur_st)
        S_OFF: begin
          cur_st   <= S_WARM;
          ctr      <= WARM_CYC;
          ocxo_ena <= 1'b1;
        end
        S_WARM: begin
          if (ctr == 24'd1) begin
            cur_st    <= S_PRST;
            ctr       <= {8'd0, RST_CYC};
            pll_rst_n <= 1'b0;
          end else begin
            ctr <= ctr - 24'd1;
          end
        end
        S_PRST: begin
          if (ctr == 24'd1) begin
            cur_st    <= S_PWAIT;
            ctr       <= LOCK_CYC;
            pll_rst_n <= 1'b1;
          end else begin
            ctr <= ctr - 24'd1;
          end
        end
        S_PWAIT: begin
          if (lock_s) begin
            cur_st  <= S_DAC;
            ctr     <= {8'd0, STEP_CYC};
            dac_ena <= 1'b1;
          end
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
          else if (ctr == 24'd1) begin
            if (retry == 2'd2) begin
              // Third attempt without lock: park with only the OCXO powered
              cur_st    <= S_FAULT;
              ctr       <= 24'd0;
              fault     <= 1'b1;
              pll_rst_n <= 1'b0;
              dac_ena   <= 1'b0;
              gps_ena   <= 1'b0;
              disp_ena  <= 1'b0;
              ready     <= 1'b0;
            end else begin
              retry     <= retry + 2'd1;
              cur_st    <= S_PRST;
              ctr       <= {8'd0, RST_CYC};
              pll_rst_n <= 1'b0;
            end
          end else begin
            ctr <= ctr - 24'd1;
          end
`endif
        end
        S_DAC, S_GPS, S_RUN: begin
          if (!lock_s) begin
            // Lock lost: re-pulse the PLL reset, keep OCXO and GPS powered
            cur_st    <= S_PRST;
            ctr       <= {8'd0, RST_CYC};
            pll_rst_n <= 1'b0;
            dac_ena   <= 1'b0;
            disp_ena  <= 1'b0;
            ready     <= 1'b0;
          end else if (cur_st == S_DAC) begin
            if (ctr == 24'd1) begin
              cur_st  <= S_GPS;
              ctr     <= {8'd0, STEP_CYC};
              gps_ena <= 1'b1;
            end else begin
              ctr <= ctr - 24'd1;
            end
          end else if (cur_st == S_GPS) begin
            if (ctr == 24'd1) begin
              cur_st   <= S_RUN;
              ctr      <= 24'd0;
              disp_ena <= 1'b1;
              ready    <= 1'b1;
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
              retry    <= 2'd0;
`endif
            end else begin
              ctr <= ctr - 24'd1;
            end
          end
        end
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
        S_FAULT: begin
          cur_st <= S_FAULT;
        end
`endif
        default: begin
          cur_st    <= S_OFF;
          ctr       <= 24'd0;
          ocxo_ena  <= 1'b0;
          pll_rst_n <= 1'b0;
          dac_ena   <= 1'b0;
          gps_ena   <= 1'b0;
          disp_ena  <= 1'b0;
          ready     <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_seq.sv
// tb/tb_pwr_seq.sv - scoreboard testbench for pwr_seq (output-change events checked in order)
module tb_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       locked;
  logic       ocxo_ena, pll_rst_n, dac_ena, gps_ena, disp_ena, ready, fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  typedef struct {
    int         edge_n;
    logic [9:0] v;
  } exp_t;
  exp_t q[$];

  pwr_seq #(
    .WARM_CYC(24'd10),
    .RST_CYC (16'd4),
    .STEP_CYC(16'd3),
    .LOCK_CYC(24'd20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .locked   (locked),
    .ocxo_ena (ocxo_ena),
    .pll_rst_n(pll_rst_n),
    .dac_ena  (dac_ena),
    .gps_ena  (gps_ena),
    .disp_ena (disp_ena),
    .ready    (ready),
    .fault    (fault),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] mk(input int st, input bit f, input bit r, input bit d,
                                    input bit g, input bit dc, input bit p, input bit o);
    logic [2:0] s3;
    s3 = st[2:0];
    return {s3, f, r, d, g, dc, p, o};
  endfunction

  function automatic logic [9:0] outs();
    return {state, fault, ready, disp_ena, gps_ena, dac_ena, pll_rst_n, ocxo_ena};
  endfunction

  task automatic push(input int e, input logic [9:0] v);
    exp_t x;
    x.edge_n = e;
    x.v      = v;
    q.push_back(x);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Monitor: every change of the output vector must match the next expected event
  logic [9:0] prev;
  always @(negedge clk) begin
    logic [9:0] cur;
    exp_t       e;
    cur = outs();
    if (mon_en && cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: at edge %0d got %b, required no change from %b", cyc, cur, prev);
      end else begin
        e = q.pop_front();
        if (e.edge_n != cyc || e.v !== cur) begin
          errors++;
          $display("FAIL out_event: at edge %0d got %b, required edge %0d value %b",
                   cyc, cur, e.edge_n, e.v);
        end
      end
    end
    prev = cur;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, e, b2, b3;
    rst_n  = 1'b0;
    en     = 1'b0;
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 10'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Nominal bring-up: edge b samples en=1
    en = 1'b1;
    b  = cyc + 1;
    push(b,      mk(1, 0, 0, 0, 0, 0, 0, 1));
    push(b + 10, mk(2, 0, 0, 0, 0, 0, 0, 1));
    push(b + 14, mk(3, 0, 0, 0, 0, 0, 1, 1));
    push(b + 19, mk(4, 0, 0, 0, 0, 1, 1, 1));
    push(b + 22, mk(5, 0, 0, 0, 1, 1, 1, 1));
    push(b + 25, mk(6, 0, 1, 1, 1, 1, 1, 1));
    wait_until(b + 16);
    locked = 1'b1;

    // Lock loss in RUN for 5 cycles
    e = b + 30;
    wait_until(e);
    locked = 1'b0;
    push(e + 3,  mk(2, 0, 0, 0, 1, 0, 0, 1));
    push(e + 7,  mk(3, 0, 0, 0, 1, 0, 1, 1));
    push(e + 8,  mk(4, 0, 0, 0, 1, 1, 1, 1));
    push(e + 11, mk(5, 0, 0, 0, 1, 1, 1, 1));
    push(e + 14, mk(6, 0, 1, 1, 1, 1, 1, 1));
    wait_until(e + 5);
    locked = 1'b1;

    // Async reset mid-RUN, between clock edges
    wait_until(e + 20);
    #2;
    push(cyc, 10'd0);
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", outs(), 10'd0);
    en     = 1'b0;
    locked = 1'b0;
    wait_until(cyc + 2);
    rst_n = 1'b1;

    // Abort mid-warm, then full restart
    wait_until(cyc + 1);
    en = 1'b1;
    b2 = cyc + 1;
    push(b2,     mk(1, 0, 0, 0, 0, 0, 0, 1));
    push(b2 + 5, 10'd0);
    wait_until(b2 + 4);
    en = 1'b0;
    wait_until(b2 + 7);
    en = 1'b1;
    b3 = cyc + 1;
    push(b3,      mk(1, 0, 0, 0, 0, 0, 0, 1));
    push(b3 + 10, mk(2, 0, 0, 0, 0, 0, 0, 1));
    push(b3 + 14, mk(3, 0, 0, 0, 0, 0, 1, 1));

`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
    // Lock never arrives: three attempts, then FAULT
    push(b3 + 34, mk(2, 0, 0, 0, 0, 0, 0, 1));
    push(b3 + 38, mk(3, 0, 0, 0, 0, 0, 1, 1));
    push(b3 + 58, mk(2, 0, 0, 0, 0, 0, 0, 1));
    push(b3 + 62, mk(3, 0, 0, 0, 0, 0, 1, 1));
    push(b3 + 82, mk(7, 1, 0, 0, 0, 0, 0, 1));
    push(b3 + 91, 10'd0);
    wait_until(b3 + 90);
    check("fault_hold", outs(), mk(7, 1, 0, 0, 0, 0, 0, 1));
    en = 1'b0;
`else
    // Lock never arrives: PWAIT holds indefinitely with no fault
    wait_until(b3 + 14 + 1000);
    check("pwait_hold", outs(), mk(3, 0, 0, 0, 0, 0, 1, 1));
    push(cyc + 1, 10'd0);
    en = 1'b0;
`endif

    wait_until(cyc + 4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0 (next edge %0d value %b)",
               q.size(), q[0].edge_n, q[0].v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
